bldc_commutation_pwm: RTL and testbench

// Hall-sensor commutation decoder plus three complementary PWM gate drivers with

---
 rtl/bldc_commutation_pwm_if.sv | 24 ++
 rtl/bldc_commutation_pwm.sv | 110 +++++++++++
 tb/tb_bldc_commutation_pwm.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bldc_commutation_pwm_if.sv
// Motor-control side bundle for the BLDC commutation/PWM block: drive requests in,
// gate drives and hall decode out.
interface bldc_commutation_pwm_if #(
  parameter int unsigned DCW = 10
);
  logic           en;
  logic [2:0]     hall;
  logic [DCW-1:0] duty_cycle;
  logic [2:0]     phaseH;
  logic [2:0]     phaseL;
  logic [2:0]     u;
  logic [2:0]     z;
  logic           hall_valid;

  modport master (
    output en, hall, duty_cycle,
    input  phaseH, phaseL, u, z, hall_valid
  );

  modport slave (
    input  en, hall, duty_cycle,
    output phaseH, phaseL, u, z, hall_valid
  );
endinterface

// File: rtl/bldc_commutation_pwm.sv
// Six-step hall commutation decoder driving three complementary PWM half-bridges,
// with per-phase dead-time so high and low gates of one phase never overlap.
module bldc_commutation_pwm #(
  parameter int unsigned MAX_COUNTER         = 'h3FF,
  parameter int unsigned COUNTER_WIDTH       = 10,
  parameter int unsigned DUTY_CYCLE_WIDTH    = 10,
  parameter int unsigned MAX_DUTY_CYCLE      = 'h3FF,
  parameter int unsigned DUTY_CYCLE_STEP_RES = 1,
  parameter int unsigned DEAD_TIME           = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  bldc_commutation_pwm_if.slave  bus
);

  localparam int unsigned DTW  = (DEAD_TIME < 1) ? 1 : $clog2(DEAD_TIME + 1);
  localparam int unsigned CMPW = 32;

  typedef enum logic [1:0] {TGT_FLOAT, TGT_HIGH, TGT_LOW} target_e;

  logic [2:0]                hs1_q, hs2_q;
  logic [COUNTER_WIDTH-1:0]  cnt_q, cnt_d;
  logic [2:0]                ph_q, ph_d, pl_q, pl_d;
  logic [2:0][DTW-1:0]       off_q, off_d;
  logic [2:0]                u_c, z_c;
  logic                      hall_valid_c;
  logic [DUTY_CYCLE_WIDTH-1:0] duty_c;
  logic [CMPW-1:0]           cmp_c;
  logic                      pwm_c;
  target_e                   tgt_c [3];

  assign duty_c = bus.duty_cycle;

  // Six-step decode of the synchronized hall code; illegal codes float everything.
  always_comb begin
    u_c          = 3'b000;
    z_c          = 3'b111;
    hall_valid_c = 1'b0;
    case (hs2_q)
      3'b101: begin u_c = 3'b001; z_c = 3'b100; hall_valid_c = 1'b1; end
      3'b100: begin u_c = 3'b001; z_c = 3'b010; hall_valid_c = 1'b1; end
      3'b110: begin u_c = 3'b010; z_c = 3'b001; hall_valid_c = 1'b1; end
      3'b010: begin u_c = 3'b010; z_c = 3'b100; hall_valid_c = 1'b1; end
      3'b011: begin u_c = 3'b100; z_c = 3'b010; hall_valid_c = 1'b1; end
      3'b001: begin u_c = 3'b100; z_c = 3'b001; hall_valid_c = 1'b1; end
      default: begin end
    endcase
  end

  // Full-scale duty pushes the compare past the counter range so pwm never drops.
  always_comb begin
    if (CMPW'(duty_c) >= CMPW'(MAX_DUTY_CYCLE)) begin
      cmp_c = CMPW'(MAX_COUNTER) + CMPW'(1);
    end else begin
      cmp_c = CMPW'(duty_c) * CMPW'(DUTY_CYCLE_STEP_RES);
    end
    pwm_c = (CMPW'(cnt_q) < cmp_c);
    cnt_d = (cnt_q == COUNTER_WIDTH'(MAX_COUNTER)) ? '0 : cnt_q + COUNTER_WIDTH'(1);
  end

  // Gate next-state: turn-off is immediate, turn-on waits for a saturated off-counter.
  always_comb begin
    ph_d  = '0;
    pl_d  = '0;
    off_d = '0;
    for (int j = 0; j < 3; j++) begin
      tgt_c[j] = TGT_FLOAT;
      if (bus.en && hall_valid_c && !z_c[j]) begin
        tgt_c[j] = (u_c[j] && pwm_c) ? TGT_HIGH : TGT_LOW;
      end
      case (tgt_c[j])
        TGT_HIGH: ph_d[j] = ph_q[j] || (!pl_q[j] && (off_q[j] == DTW'(DEAD_TIME)));
        TGT_LOW:  pl_d[j] = pl_q[j] || (!ph_q[j] && (off_q[j] == DTW'(DEAD_TIME)));
        default:  begin end
      endcase
      if (ph_d[j] || pl_d[j]) begin
        off_d[j] = '0;
      end else if (off_q[j] == DTW'(DEAD_TIME)) begin
        off_d[j] = off_q[j];
      end else begin
        off_d[j] = off_q[j] + DTW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs1_q <= '0;
      hs2_q <= '0;
      cnt_q <= '0;
      ph_q  <= '0;
      pl_q  <= '0;
      off_q <= '0;
    end else begin
      hs1_q <= bus.hall;
      hs2_q <= hs1_q;
      cnt_q <= cnt_d;
      ph_q  <= ph_d;
      pl_q  <= pl_d;
      off_q <= off_d;
    end
  end

  assign bus.phaseH     = ph_q;
  assign bus.phaseL     = pl_q;
  assign bus.u          = u_c;
  assign bus.z          = z_c;
  assign bus.hall_valid = hall_valid_c;

endmodule

// File: tb/tb_bldc_commutation_pwm.sv
// Directed bench for bldc_commutation_pwm: scoreboarded expectations plus per-cycle
// gate overlap and dead-time checks.
module tb_bldc_commutation_pwm;

  localparam int unsigned DT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bldc_commutation_pwm_if #(.DCW(10)) bus ();

  bldc_commutation_pwm #(
    .MAX_COUNTER('h3FF), .COUNTER_WIDTH(10), .DUTY_CYCLE_WIDTH(10),
    .MAX_DUTY_CYCLE('h3FF), .DUTY_CYCLE_STEP_RES(1), .DEAD_TIME(DT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t  sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   off_run [3] = '{0, 0, 0};
  logic [2:0] prev_on = 3'b000;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    sb_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL sb_empty: observed %0h expected an entry", obs);
    end else begin
      e = sb_q.pop_front();
      cmp(e.tag, obs, e.exp);
    end
  endtask

  // Advance to the next falling edge and check the gate safety properties.
  task automatic tick();
    logic [2:0] on;
    @(negedge clk);
    cmp("overlap", 32'(bus.phaseH & bus.phaseL), 32'd0);
    on = bus.phaseH | bus.phaseL;
    for (int j = 0; j < 3; j++) begin
      if (on[j] && !prev_on[j]) cmp("deadtime", 32'(off_run[j] >= int'(DT)), 32'd1);
      if (on[j]) off_run[j] = 0;
      else       off_run[j]++;
    end
    prev_on = on;
  endtask

  function automatic logic [5:0] dec(input logic [2:0] h);
    case (h)
      3'b101: return {3'b001, 3'b100};
      3'b100: return {3'b001, 3'b010};
      3'b110: return {3'b010, 3'b001};
      3'b010: return {3'b010, 3'b100};
      3'b011: return {3'b100, 3'b010};
      3'b001: return {3'b100, 3'b001};
      default: return {3'b000, 3'b111};
    endcase
  endfunction

  task automatic expect_gates(input string tag, input logic [2:0] h, input logic [2:0] l);
    sb_push({tag, "_H"}, 32'(h));
    sb_push({tag, "_L"}, 32'(l));
    sb_pop(32'(bus.phaseH));
    sb_pop(32'(bus.phaseL));
  endtask

  initial begin
    logic [2:0] seq [6];
    logic [5:0] prev_d, new_d;
    int hcnt, lcnt, ocnt, bcnt, ccnt, run, rmin, rmax;
    bit seen, aprev;

    bus.en = 1'b0;
    bus.hall = 3'b000;
    bus.duty_cycle = '0;

    // Reset state
    tick(); tick();
    sb_push("rst_hv", 32'd0);
    sb_push("rst_u", 32'd0);
    sb_push("rst_z", 32'h7);
    sb_pop(32'(bus.hall_valid));
    sb_pop(32'(bus.u));
    sb_pop(32'(bus.z));
    expect_gates("rst", 3'b000, 3'b000);

    // Release with hall=101, duty 0: B low, A low via synchronous rectification, C off
    bus.en = 1'b1;
    bus.hall = 3'b101;
    tick();
    rst = 1'b0;
    for (int k = 0; k < int'(DT) + 3; k++) begin
      tick();
      if (bus.phaseL[1]) break;
    end
    expect_gates("start", 3'b000, 3'b011);
    sb_push("start_u", 32'h1);
    sb_push("start_z", 32'h4);
    sb_push("start_hv", 32'd1);
    sb_pop(32'(bus.u));
    sb_pop(32'(bus.z));
    sb_pop(32'(bus.hall_valid));

    // 50% duty: 1024-clk window on phase A
    bus.duty_cycle = 10'd512;
    for (int k = 0; k < 1100; k++) tick();
    hcnt = 0; lcnt = 0; ocnt = 0; bcnt = 0; ccnt = 0;
    run = 0; rmin = 9999; rmax = -1; seen = 1'b0; aprev = 1'b1;
    for (int k = 0; k < 1024; k++) begin
      tick();
      if (bus.phaseH[0]) hcnt++;
      if (bus.phaseL[0]) lcnt++;
      if (!bus.phaseH[0] && !bus.phaseL[0]) begin
        ocnt++;
        run++;
      end else begin
        if (!aprev && seen) begin
          if (run < rmin) rmin = run;
          if (run > rmax) rmax = run;
        end
        seen = 1'b1;
        run = 0;
      end
      aprev = bus.phaseH[0] | bus.phaseL[0];
      if (bus.phaseL[1] && !bus.phaseH[1]) bcnt++;
      if (!bus.phaseL[2] && !bus.phaseH[2]) ccnt++;
    end
    sb_push("pwm_h_clks", 32'd510);
    sb_push("pwm_l_clks", 32'd510);
    sb_push("pwm_off_clks", 32'd4);
    sb_push("dead_min", 32'd2);
    sb_push("dead_max", 32'd2);
    sb_push("b_low_clks", 32'd1024);
    sb_push("c_off_clks", 32'd1024);
    sb_pop(32'(hcnt));
    sb_pop(32'(lcnt));
    sb_pop(32'(ocnt));
    sb_pop(32'(rmin));
    sb_pop(32'(rmax));
    sb_pop(32'(bcnt));
    sb_pop(32'(ccnt));

    // Full duty, hall walked through the six states
    bus.duty_cycle = 10'h3FF;
    for (int k = 0; k < 8; k++) tick();
    seq = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
    prev_d = dec(3'b101);
    for (int i = 0; i < 6; i++) begin
      bus.hall = seq[i];
      new_d = dec(seq[i]);
      sb_push("step_u_1clk", 32'(prev_d[5:3]));
      tick();
      sb_pop(32'(bus.u));
      sb_push("step_u", 32'(new_d[5:3]));
      sb_push("step_z", 32'(new_d[2:0]));
      sb_push("step_hv", 32'd1);
      tick();
      sb_pop(32'(bus.u));
      sb_pop(32'(bus.z));
      sb_pop(32'(bus.hall_valid));
      for (int k = 0; k < 6; k++) tick();
      expect_gates("step_gates", new_d[5:3], ~new_d[5:3] & ~new_d[2:0]);
      prev_d = new_d;
    end

    // Illegal hall codes
    bus.hall = 3'b000;
    tick(); tick(); tick();
    sb_push("h000_hv", 32'd0);
    sb_push("h000_z", 32'h7);
    sb_pop(32'(bus.hall_valid));
    sb_pop(32'(bus.z));
    expect_gates("h000", 3'b000, 3'b000);
    bus.hall = 3'b101;
    for (int k = 0; k < 8; k++) tick();
    bus.hall = 3'b111;
    tick(); tick(); tick();
    sb_push("h111_hv", 32'd0);
    sb_push("h111_z", 32'h7);
    sb_push("h111_u", 32'd0);
    sb_pop(32'(bus.hall_valid));
    sb_pop(32'(bus.z));
    sb_pop(32'(bus.u));
    expect_gates("h111", 3'b000, 3'b000);

    // Enable drop and re-enable
    bus.hall = 3'b101;
    for (int k = 0; k < 8; k++) tick();
    expect_gates("en_pre", 3'b001, 3'b010);
    bus.en = 1'b0;
    tick();
    expect_gates("en_off", 3'b000, 3'b000);
    bus.en = 1'b1;
    tick();
    expect_gates("en_dead", 3'b000, 3'b000);
    tick();
    expect_gates("en_on", 3'b001, 3'b010);

    // Asynchronous reset between clock edges
    tick();
    #2 rst = 1'b1;
    #1;
    expect_gates("arst", 3'b000, 3'b000);
    sb_push("arst_u", 32'd0);
    sb_push("arst_z", 32'h7);
    sb_push("arst_hv", 32'd0);
    sb_pop(32'(bus.u));
    sb_pop(32'(bus.z));
    sb_pop(32'(bus.hall_valid));
    tick();
    rst = 1'b0;
    tick();
    expect_gates("rel_1", 3'b000, 3'b000);
    tick();
    expect_gates("rel_2", 3'b000, 3'b000);
    sb_push("rel_u", 32'h1);
    sb_pop(32'(bus.u));
    tick();
    expect_gates("rel_3", 3'b001, 3'b010);

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL sb_leftover: observed %0d entries expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
